// File: rtl/dmem_dma_pkg.sv
// dmem_dma_pkg: shared constants for the block-copy/fill engine and its neighbours.
// Mode encoding, FSM state encoding and the data-memory geometry defaults
// used by the CPU, the data memory and this engine.
package dmem_dma_pkg;

  // Data-memory geometry shared with the CPU and data memory
  localparam int DMEM_AW = 8;
  localparam int DMEM_DW = 16;

  // Command modes
  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  // Engine FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/dmem_dma.sv
// dmem_dma: block copy / fill engine driving the data-memory port while busy.
// Copy costs 2 cycles per word (read then write), fill 1 cycle per word; done
// pulses one cycle after the last write. start is only honoured in IDLE.
import dmem_dma_pkg::*;

module dmem_dma #(
  parameter int AW = DMEM_AW,
  parameter int DW = DMEM_DW,
  parameter int LW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mode,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [LW-1:0] len,
  input  logic [DW-1:0] fill_val,
  output logic          busy,
  output logic          done,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  logic [1:0]    state_q, state_d;
  logic          mode_q, mode_d;
  logic          desc_q, desc_d;
  logic [AW-1:0] src_ptr_q, src_ptr_d;
  logic [AW-1:0] dst_ptr_q, dst_ptr_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] data_q, data_d;
  logic [DW-1:0] fill_q, fill_d;

  // Copy runs descending when the destination sits above the source so an
  // overlapping region is never overwritten before it has been read.
  logic start_desc;
  assign start_desc = (mode == MODE_COPY) && (dst > src);

  // Next-state logic: command latch, pointer stepping and word counting
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    desc_d    = desc_q;
    src_ptr_d = src_ptr_q;
    dst_ptr_d = dst_ptr_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    fill_d    = fill_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d = mode;
          desc_d = start_desc;
          fill_d = fill_val;
          cnt_d  = len;
          if (start_desc) begin
            // Pointers wrap modulo 2^AW; len==2^AW truncates to 0, giving base-1
            src_ptr_d = src + AW'(len) - AW'(1);
            dst_ptr_d = dst + AW'(len) - AW'(1);
          end else begin
            src_ptr_d = src;
            dst_ptr_d = dst;
          end
          if (len == '0)               state_d = ST_DONE;
          else if (mode == MODE_FILL)  state_d = ST_WR;
          else                         state_d = ST_RD;
        end
      end
      ST_RD: begin
        data_d  = mem_rdata;
        state_d = ST_WR;
      end
      ST_WR: begin
        src_ptr_d = desc_q ? src_ptr_q - AW'(1) : src_ptr_q + AW'(1);
        dst_ptr_d = desc_q ? dst_ptr_q - AW'(1) : dst_ptr_q + AW'(1);
        cnt_d     = cnt_q - LW'(1);
        if (cnt_q == LW'(1))          state_d = ST_DONE;
        else if (mode_q == MODE_FILL) state_d = ST_WR;
        else                          state_d = ST_RD;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset; reset drops straight to IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_COPY;
      desc_q    <= 1'b0;
      src_ptr_q <= '0;
      dst_ptr_q <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      fill_q    <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      desc_q    <= desc_d;
      src_ptr_q <= src_ptr_d;
      dst_ptr_q <= dst_ptr_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      fill_q    <= fill_d;
    end
  end

  // Port outputs are pure decodes of state, so mem_we can only be high while busy
  assign busy      = (state_q == ST_RD) || (state_q == ST_WR);
  assign done      = (state_q == ST_DONE);
  assign mem_we    = (state_q == ST_WR);
  assign mem_addr  = (state_q == ST_RD) ? src_ptr_q :
                     (state_q == ST_WR) ? dst_ptr_q : '0;
  assign mem_wdata = (state_q != ST_WR)     ? '0     :
                     (mode_q == MODE_FILL)  ? fill_q : data_q;

endmodule

// File: tb/tb_dmem_dma.sv
// tb_dmem_dma: self-checking bench for dmem_dma with a bench-owned data memory.
// Directed scenarios plus randomized copy/fill commands against a word-level model.
// Checks data, write order, busy length, done timing and reset abort.
module tb_dmem_dma;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [7:0]  src = '0;
  logic [7:0]  dst = '0;
  logic [8:0]  len = '0;
  logic [15:0] fill_val = '0;
  logic        busy, done, mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata;

  logic [15:0] mem [0:255];
  logic [15:0] ref_mem [0:255];
  logic [7:0]  wlog[$];
  logic [7:0]  exp_w[$];

  int total = 0;
  int bad = 0;

  dmem_dma dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .src(src), .dst(dst),
    .len(len), .fill_val(fill_val), .busy(busy), .done(done), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] = mem_wdata;
      wlog.push_back(mem_addr);
    end
  end

  task automatic preload_plan();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 3; i++) mem[i] = 16'hfffe;
    for (int i = 4; i < 7; i++) mem[i] = 16'hffff;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
  endtask

  // Word-level reference: one word moved per step, in the order the spec fixes
  task automatic model_cmd(input logic m, input logic [7:0] s, input logic [7:0] d,
                           input int l, input logic [15:0] f);
    int i;
    logic [7:0] a, b;
    exp_w.delete();
    for (int k = 0; k < l; k++) begin
      i = (m == 1'b0 && d > s) ? l - 1 - k : k;
      a = 8'((int'(d) + i) % 256);
      b = 8'((int'(s) + i) % 256);
      ref_mem[a] = m ? f : ref_mem[b];
      exp_w.push_back(a);
    end
  endtask

  // Issues one command and observes it; n=0 is the first cycle after start is taken
  task automatic run_cmd(input logic m, input logic [7:0] s, input logic [7:0] d,
                         input int l, input logic [15:0] f,
                         output int bcyc, output int didx, output int stray);
    wlog.delete();
    @(negedge clk);
    start = 1'b1; mode = m; src = s; dst = d; len = 9'(l); fill_val = f;
    @(negedge clk);
    start = 1'b0;
    bcyc = 0; didx = -1; stray = 0;
    for (int n = 0; n < 1200 && didx < 0; n++) begin
      if (busy) bcyc++;
      if (!busy && mem_we) stray++;
      if (done) didx = n;
      if (didx < 0) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", mem_we); end
    total++; if (mem_addr !== 8'h00) begin bad++; $display("FAIL reset_addr got=%h exp=00", mem_addr); end
    total++; if (mem_wdata !== 16'h0000) begin bad++; $display("FAIL reset_wdata got=%h exp=0000", mem_wdata); end
  endtask

  task automatic test_copy();
    int bc, di, st, nb;
    model_cmd(1'b0, 8'd0, 8'd16, 4, 16'h0);
    run_cmd(1'b0, 8'd0, 8'd16, 4, 16'h0, bc, di, st);
    total++; if (bc != 8) begin bad++; $display("FAIL copy_busy got=%0d exp=8", bc); end
    total++; if (di != 8) begin bad++; $display("FAIL copy_done_idx got=%0d exp=8", di); end
    total++; if (st != 0) begin bad++; $display("FAIL copy_stray_we got=%0d exp=0", st); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL copy_done_width got=%b exp=0", done); end
    total++;
    if ({mem[16], mem[17], mem[18], mem[19]} !== {16'hfffe, 16'hfffe, 16'hfffe, 16'h0000}) begin
      bad++; $display("FAIL copy_data got=%h %h %h %h exp=fffe fffe fffe 0000", mem[16], mem[17], mem[18], mem[19]);
    end
    nb = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) nb++;
    total++; if (nb != 0) begin bad++; $display("FAIL copy_mem_image got=%0d diffs exp=0", nb); end
  endtask

  task automatic test_fill();
    int bc, di, st;
    model_cmd(1'b1, 8'd0, 8'd8, 3, 16'h1234);
    run_cmd(1'b1, 8'd0, 8'd8, 3, 16'h1234, bc, di, st);
    total++; if (bc != 3) begin bad++; $display("FAIL fill_busy got=%0d exp=3", bc); end
    total++; if (di != 3) begin bad++; $display("FAIL fill_done_idx got=%0d exp=3", di); end
    total++;
    if ({mem[8], mem[9], mem[10], mem[11]} !== {16'h1234, 16'h1234, 16'h1234, 16'h0000}) begin
      bad++; $display("FAIL fill_data got=%h %h %h %h exp=1234 1234 1234 0000", mem[8], mem[9], mem[10], mem[11]);
    end
  endtask

  task automatic test_overlap();
    int bc, di, st;
    logic [7:0] ea [4];
    ea[0] = 8'd5; ea[1] = 8'd4; ea[2] = 8'd3; ea[3] = 8'd2;
    model_cmd(1'b0, 8'd0, 8'd2, 4, 16'h0);
    run_cmd(1'b0, 8'd0, 8'd2, 4, 16'h0, bc, di, st);
    total++; if (wlog.size() != 4) begin bad++; $display("FAIL ovl_wr_count got=%0d exp=4", wlog.size()); end
    for (int i = 0; i < 4 && i < wlog.size(); i++) begin
      total++; if (wlog[i] !== ea[i]) begin bad++; $display("FAIL ovl_wr_order[%0d] got=%0d exp=%0d", i, wlog[i], ea[i]); end
    end
    total++;
    if ({mem[0], mem[1], mem[2], mem[3], mem[4], mem[5], mem[6]} !==
        {16'hfffe, 16'hfffe, 16'hfffe, 16'hfffe, 16'hfffe, 16'h0000, 16'hffff}) begin
      bad++; $display("FAIL ovl_data got=%h %h %h %h %h %h %h", mem[0], mem[1], mem[2], mem[3], mem[4], mem[5], mem[6]);
    end
  endtask

  task automatic test_len0();
    int bc, di, st;
    run_cmd(1'b1, 8'd0, 8'd40, 0, 16'h5555, bc, di, st);
    total++; if (di != 0) begin bad++; $display("FAIL len0_done_idx got=%0d exp=0", di); end
    total++; if (bc != 0) begin bad++; $display("FAIL len0_busy got=%0d exp=0", bc); end
    total++; if (wlog.size() != 0) begin bad++; $display("FAIL len0_writes got=%0d exp=0", wlog.size()); end
  endtask

  task automatic test_wrap();
    int bc, di, st;
    model_cmd(1'b1, 8'd0, 8'd254, 4, 16'ha5a5);
    run_cmd(1'b1, 8'd0, 8'd254, 4, 16'ha5a5, bc, di, st);
    total++;
    if ({mem[254], mem[255], mem[0], mem[1], mem[2], mem[253]} !==
        {16'ha5a5, 16'ha5a5, 16'ha5a5, 16'ha5a5, 16'hfffe, 16'h0000}) begin
      bad++; $display("FAIL wrap_data got=%h %h %h %h %h %h", mem[254], mem[255], mem[0], mem[1], mem[2], mem[253]);
    end
    total++; if (bc != 4) begin bad++; $display("FAIL wrap_busy got=%0d exp=4", bc); end
  endtask

  task automatic test_abort();
    int nd, nbz, nb;
    wlog.delete();
    @(negedge clk);
    start = 1'b1; mode = 1'b1; src = 8'd0; dst = 8'd32; len = 9'd8; fill_val = 16'hbeef;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; mode = 1'b0; src = 8'd64; dst = 8'd96; len = 9'd5;
    @(negedge clk);
    start = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL abort_we got=%b exp=0", mem_we); end
    nd = 0; nbz = 0;
    for (int i = 0; i < 5; i++) begin
      if (done) nd++;
      if (busy) nbz++;
      @(negedge clk);
    end
    total++; if (nd != 0) begin bad++; $display("FAIL abort_done got=%0d pulses exp=0", nd); end
    total++; if (nbz != 0) begin bad++; $display("FAIL abort_restart got=%0d busy cycles exp=0", nbz); end
    total++; if (wlog.size() != 3) begin bad++; $display("FAIL abort_wr_count got=%0d exp=3", wlog.size()); end
    for (int i = 32; i < 35; i++) ref_mem[i] = 16'hbeef;
    nb = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) nb++;
    total++; if (nb != 0) begin bad++; $display("FAIL abort_mem_image got=%0d diffs exp=0 (m35=%h)", nb, mem[35]); end
  endtask

  task automatic test_random();
    int bc, di, st, nb, l, wbad;
    logic m;
    logic [7:0] s, d;
    logic [15:0] f;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'($urandom);
      ref_mem[i] = mem[i];
    end
    for (int it = 0; it < 24; it++) begin
      m = 1'($urandom_range(0, 1));
      s = 8'($urandom);
      d = 8'($urandom);
      f = 16'($urandom);
      l = (it == 5) ? 256 : int'($urandom_range(0, 20));
      if (it == 5) m = 1'b0;
      model_cmd(m, s, d, l, f);
      run_cmd(m, s, d, l, f, bc, di, st);
      total++; if (bc != (m ? l : 2 * l)) begin bad++; $display("FAIL rnd%0d_busy got=%0d exp=%0d", it, bc, m ? l : 2 * l); end
      total++; if (di != bc) begin bad++; $display("FAIL rnd%0d_done_idx got=%0d exp=%0d", it, di, bc); end
      total++; if (st != 0) begin bad++; $display("FAIL rnd%0d_stray_we got=%0d exp=0", it, st); end
      wbad = (wlog.size() != exp_w.size()) ? 1 : 0;
      for (int k = 0; k < wlog.size() && k < exp_w.size(); k++) if (wlog[k] !== exp_w[k]) wbad++;
      total++; if (wbad != 0) begin bad++; $display("FAIL rnd%0d_wr_seq got=%0d diffs exp=0", it, wbad); end
      nb = 0;
      for (int k = 0; k < 256; k++) if (mem[k] !== ref_mem[k]) nb++;
      total++; if (nb != 0) begin bad++; $display("FAIL rnd%0d_mem_image got=%0d diffs exp=0", it, nb); end
    end
  endtask

  initial begin
    preload_plan();
    test_reset();
    test_copy();
    test_fill();
    test_overlap();
    test_len0();
    test_wrap();
    test_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
